// File: rtl/fft_peak_detect.sv
// Streaming peak finder for FFT output frames: reports the strongest bin in the
// lower half of each frame and flags frames whose length is not 2^N_LOG2.
module fft_peak_detect #(
  parameter int N_LOG2  = 10,
  parameter bit SKIP_DC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              di_en,
  input  logic              di_last,
  input  logic [31:0]       din,
  output logic              pk_valid,
  output logic [N_LOG2-1:0] pk_bin,
  output logic [31:0]       pk_pow,
  output logic              frame_err
);

  localparam logic [N_LOG2-1:0] LAST_BIN = '1;

  // ---------------------------------------------------------------------------
  // Input side: bin counter and per-sample frame classification
  // ---------------------------------------------------------------------------
  logic [N_LOG2-1:0] bin_cnt;
  logic              at_end;
  logic              close_frame;
  logic              len_err;
  logic              in_range;

  assign at_end      = (bin_cnt == LAST_BIN);
  // A frame closes on di_last or on the last bin, whichever comes first; the
  // two disagreeing means the frame was short or long.
  assign close_frame = di_last || at_end;
  assign len_err     = di_last ^ at_end;
  assign in_range    = !bin_cnt[N_LOG2-1] && (!SKIP_DC || (bin_cnt != '0));

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge value of its sources, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_cnt <= '0;
    end else if (di_en) begin
      bin_cnt <= close_frame ? '0 : bin_cnt + N_LOG2'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: register the sample and its bookkeeping
  // ---------------------------------------------------------------------------
  logic                s1_valid;
  logic signed [15:0]  s1_re;
  logic signed [15:0]  s1_im;
  logic [N_LOG2-1:0]   s1_bin;
  logic                s1_last;
  logic                s1_err;
  logic                s1_in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid    <= 1'b0;
      s1_re       <= '0;
      s1_im       <= '0;
      s1_bin      <= '0;
      s1_last     <= 1'b0;
      s1_err      <= 1'b0;
      s1_in_range <= 1'b0;
    end else begin
      s1_valid <= di_en;
      s1_last  <= di_en && close_frame;
      s1_err   <= di_en && close_frame && len_err;
      if (di_en) begin
        s1_re       <= din[15:0];
        s1_im       <= din[31:16];
        s1_bin      <= bin_cnt;
        s1_in_range <= in_range;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: sum of squares
  // ---------------------------------------------------------------------------
  logic signed [31:0] re_ext;
  logic signed [31:0] im_ext;
  logic signed [31:0] re_sq;
  logic signed [31:0] im_sq;
  logic [31:0]        pow;

  assign re_ext = {{16{s1_re[15]}}, s1_re};
  assign im_ext = {{16{s1_im[15]}}, s1_im};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  // Each square is at most 2^30, so the unsigned sum (max 2^31) never wraps.
  assign pow    = $unsigned(re_sq) + $unsigned(im_sq);

  logic              s2_valid;
  logic [31:0]       s2_pow;
  logic [N_LOG2-1:0] s2_bin;
  logic              s2_last;
  logic              s2_err;
  logic              s2_in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid    <= 1'b0;
      s2_pow      <= '0;
      s2_bin      <= '0;
      s2_last     <= 1'b0;
      s2_err      <= 1'b0;
      s2_in_range <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_err   <= s1_err;
      if (s1_valid) begin
        s2_pow      <= pow;
        s2_bin      <= s1_bin;
        s2_in_range <= s1_in_range;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: running-maximum compare/update
  // ---------------------------------------------------------------------------
  logic              max_found;
  logic [31:0]       max_pow;
  logic [N_LOG2-1:0] max_bin;
  logic              take;
  logic [31:0]       cand_pow;
  logic [N_LOG2-1:0] cand_bin;

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    take     = 1'b0;
    cand_pow = max_pow;
    cand_bin = max_bin;
    // Strictly-greater compare keeps the earlier (lower) bin on ties.
    if (s2_valid && s2_in_range) begin
      take = !max_found || (s2_pow > max_pow);
    end
    if (take) begin
      cand_pow = s2_pow;
      cand_bin = s2_bin;
    end
  end

  logic              s3_done;
  logic              s3_err;
  logic [31:0]       res_pow;
  logic [N_LOG2-1:0] res_bin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_found <= 1'b0;
      max_pow   <= '0;
      max_bin   <= '0;
      res_pow   <= '0;
      res_bin   <= '0;
      s3_done   <= 1'b0;
      s3_err    <= 1'b0;
    end else begin
      s3_done <= s2_valid && s2_last;
      s3_err  <= s2_valid && s2_last && s2_err;
      if (s2_valid && s2_last) begin
        // The maximum is cleared to zero when idle, so a frame without any
        // in-range bin naturally reports bin 0 / power 0.
        res_pow   <= cand_pow;
        res_bin   <= cand_bin;
        max_found <= 1'b0;
        max_pow   <= '0;
        max_bin   <= '0;
      end else if (take) begin
        max_found <= 1'b1;
        max_pow   <= s2_pow;
        max_bin   <= s2_bin;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result register: pulse flags, hold the last reported peak
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pk_valid  <= 1'b0;
      frame_err <= 1'b0;
      pk_bin    <= '0;
      pk_pow    <= '0;
    end else begin
      pk_valid  <= s3_done;
      frame_err <= s3_err;
      if (s3_done) begin
        pk_bin <= res_bin;
        pk_pow <= res_pow;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: a frame-level reference model
// predicts each result and its arrival cycle; outputs are compared every cycle.
module tb_fft_peak_detect;

  localparam int N_LOG2 = 10;
  localparam int NBINS  = 1 << N_LOG2;

  logic              clk = 1'b0;
  logic              rst;
  logic              di_en;
  logic              di_last;
  logic [31:0]       din;
  logic              pk_valid;
  logic [N_LOG2-1:0] pk_bin;
  logic [31:0]       pk_pow;
  logic              frame_err;

  fft_peak_detect #(.N_LOG2(N_LOG2), .SKIP_DC(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .di_en    (di_en),
    .di_last  (di_last),
    .din      (din),
    .pk_valid (pk_valid),
    .pk_bin   (pk_bin),
    .pk_pow   (pk_pow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: collect in-range powers per frame, pick the peak at close
  // ---------------------------------------------------------------------------
  typedef struct {
    int     due;
    int     bin;
    longint pow;
    bit     err;
  } res_t;

  res_t   exp_q[$];
  res_t   got_q[$];
  int     m_cnt = 0;
  int     fr_bin[$];
  longint fr_pow[$];
  int     hold_bin = 0;
  longint hold_pow = 0;

  task automatic model_step(input logic signed [15:0] re, input logic signed [15:0] im,
                            input bit last);
    int     b;
    longint p;
    bit     full;
    res_t   r;
    b    = m_cnt;
    p    = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    full = (b == NBINS - 1);
    if (b >= 1 && b < NBINS / 2) begin
      fr_bin.push_back(b);
      fr_pow.push_back(p);
    end
    if (last || full) begin
      r.bin = 0;
      r.pow = 0;
      for (int k = 0; k < fr_pow.size(); k++) begin
        if (k == 0 || fr_pow[k] > r.pow) begin
          r.bin = fr_bin[k];
          r.pow = fr_pow[k];
        end
      end
      r.due = cyc + 3;
      r.err = (last != full);
      exp_q.push_back(r);
      fr_bin.delete();
      fr_pow.delete();
      m_cnt = 0;
    end else begin
      m_cnt = b + 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: every cycle, mid-way between active edges
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : compare
    res_t e;
    res_t g;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("pk_valid_pulse", pk_valid, 1);
      check("frame_err_pulse", frame_err, e.err);
      check("pk_bin", pk_bin, e.bin);
      check("pk_pow", pk_pow, e.pow);
      hold_bin = e.bin;
      hold_pow = e.pow;
    end else begin
      check("pk_valid_idle", pk_valid, 0);
      check("frame_err_idle", frame_err, 0);
      check("pk_bin_hold", pk_bin, hold_bin);
      check("pk_pow_hold", pk_pow, hold_pow);
    end
    if (pk_valid) begin
      g.due = cyc;
      g.bin = int'(pk_bin);
      g.pow = longint'(pk_pow);
      g.err = frame_err;
      got_q.push_back(g);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic signed [15:0] re_v[4096];
  logic signed [15:0] im_v[4096];

  task automatic clear_vec();
    for (int i = 0; i < 4096; i++) begin
      re_v[i] = '0;
      im_v[i] = '0;
    end
    got_q.delete();
  endtask

  task automatic idle(input int n);
    di_en   = 1'b0;
    di_last = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int idx, input bit last);
    di_en   = 1'b1;
    di_last = last;
    din     = {im_v[idx], re_v[idx]};
    @(posedge clk);
    #1;
    model_step(re_v[idx], im_v[idx], last);
    di_en   = 1'b0;
    di_last = 1'b0;
  endtask

  task automatic run(input int start, input int len, input bit last_at_end, input int max_gap);
    for (int i = 0; i < len; i++) begin
      if (i > 0 && max_gap > 0) idle($urandom_range(0, max_gap));
      send(start + i, last_at_end && (i == len - 1));
    end
  endtask

  task automatic expect_res(input string name, input int bin, input longint pow, input bit err);
    res_t r;
    check({name, "_seen"}, got_q.size() > 0, 1);
    if (got_q.size() > 0) begin
      r = got_q.pop_front();
      check({name, "_bin"}, r.bin, bin);
      check({name, "_pow"}, r.pow, pow);
      check({name, "_err"}, r.err, err);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    exp_q.delete();
    fr_bin.delete();
    fr_pow.delete();
    m_cnt    = 0;
    hold_bin = 0;
    hold_pow = 0;
    #1;
    check("rst_pk_valid", pk_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_pk_bin", pk_bin, 0);
    check("rst_pk_pow", pk_pow, 0);
    idle(3);
    rst = 1'b1;
    idle(1);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    di_en   = 1'b0;
    di_last = 1'b0;
    din     = '0;
    rst     = 1'b1;
    #1;
    apply_reset();

    // Single tone at bin 100
    clear_vec();
    re_v[100] = 16'sd1000;
    run(0, NBINS, 1'b1, 0);
    idle(6);
    expect_res("tone", 100, 1000000, 1'b0);

    // DC excluded, upper half excluded, tie resolves to the lower bin
    clear_vec();
    re_v[0]   = 16'sd30000;
    re_v[5]   = 16'sd20;
    re_v[9]   = 16'sd20;
    re_v[600] = 16'sd32767;
    run(0, NBINS, 1'b1, 0);
    idle(6);
    expect_res("tie_dc", 5, 400, 1'b0);

    // Extreme value
    clear_vec();
    re_v[1] = -16'sd32768;
    im_v[1] = -16'sd32768;
    run(0, NBINS, 1'b1, 0);
    idle(6);
    expect_res("extreme", 1, 64'd2147483648, 1'b0);

    // Back-to-back frames with random gaps inside each frame
    clear_vec();
    re_v[3]           = 16'sd50;
    im_v[NBINS + 200] = -16'sd70;
    run(0, NBINS, 1'b1, 2);
    run(NBINS, NBINS, 1'b1, 2);
    idle(6);
    expect_res("b2b_a", 3, 2500, 1'b0);
    expect_res("b2b_b", 200, 4900, 1'b0);

    // Short frame holding only bin 0: no in-range bins
    clear_vec();
    re_v[0] = 16'sd500;
    run(0, 1, 1'b1, 0);
    idle(6);
    expect_res("dc_only", 0, 0, 1'b1);

    // Short frame, then long run; the 1025th sample restarts at bin 0
    clear_vec();
    re_v[7]    = 16'sd10;
    re_v[801]  = 16'sd3;
    re_v[1525] = 16'sd30000;
    re_v[1526] = 16'sd4;
    run(0, 501, 1'b1, 0);
    run(501, NBINS + 1, 1'b0, 0);
    run(1526, NBINS - 1, 1'b1, 0);
    idle(6);
    expect_res("short", 7, 100, 1'b1);
    expect_res("long", 300, 9, 1'b1);
    expect_res("after_long", 1, 16, 1'b0);

    // Mid-frame reset discards the partial frame
    clear_vec();
    re_v[2048 + 10] = 16'sd99;
    re_v[42]        = 16'sd5;
    run(2048, 300, 1'b0, 0);
    apply_reset();
    idle(6);
    check("no_pulse_after_reset", got_q.size(), 0);
    run(0, NBINS, 1'b1, 0);
    idle(6);
    expect_res("post_reset", 42, 25, 1'b0);

    idle(4);
    check("pending_results", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
